mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control unit for the MIPS datapath; the driving end of the ALU interface.
- Accepts one instruction word per handshake and decodes it into a 5-bit ALU operation code and datapath controls.
- Consumes the ALU zero flag to resolve branches.
- Sequences fetch, decode, execute, memory and write-back, with exactly one PC update per instruction.

Parameters:
- MEM_WAIT_MAX, 0, maximum cycles to wait for mem_ack; 0 means unbounded. Used only with the optional feature.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_b  input  1  reset, synchronous, active-low
- inst  input  32  instruction word
- inst_valid  input  1  inst is presented
- inst_ready  output  1  controller accepts inst this cycle
- alu_op  output  5  operation code to the ALU
- zero  input  1  ALU zero flag
- alu_src_imm  output  1  ALU operand 2 = immediate
- imm_zero_ext  output  1  immediate is zero-extended (andi/ori/xori); otherwise sign-extended
- reg_dst_rd  output  1  write-back destination is rd (R-type); otherwise rt
- reg_write  output  1  register-file write strobe
- mem_to_reg  output  1  write-back data comes from memory
- mem_req  output  1  data-memory request
- mem_we  output  1  store when high, load when low
- mem_ack  input  1  memory access completed
- pc_write  output  1  PC update strobe
- pc_src  output  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = register (jr)
- link  output  1  jal: write PC+4 to $31
- illegal  output  1  one-cycle pulse on an undecodable instruction
- halted  output  1  sticky after syscall
- mem_timeout  output  1  sticky timeout flag (optional feature)

Behaviour:
- Reset values: state FETCH, all outputs 0, alu_op 5'b00000.
- FETCH:
  - inst_ready = 1.
  - On inst_valid, latch inst into IR and go to DECODE.
- DECODE, 1 cycle:
  - Register all control outputs from IR.
  - alu_op is held constant from the end of DECODE until the return to FETCH.
  - Go to EXEC.
- ALU encodings: XOR 00000, SLL 00001, SLLV 11001, SRL 00010, SRLV 11010, SRA 00011, ADD 00100, SUB 00101, MULT 00110, DIV 00111, OR 01000, NOR 01001, AND 01010, SLT 01011, BEQ 01101, BNE 01110, BLEZ 01111, BGTZ 10000, BGEZ 10001, LUI 10010.
- R-type funct mapping:
  - 20/21 -> ADD; 22/23 -> SUB; 24 -> AND; 25 -> OR; 26 -> XOR; 27 -> NOR; 2A -> SLT.
  - 00 -> SLL; 02 -> SRL; 03 -> SRA; 04 -> SLLV; 06 -> SRLV; 18 -> MULT; 1A -> DIV.
  - 08 = jr; 0C = syscall.
- I-type and J-type opcode mapping:
  - 08/09 -> ADD; 0C -> AND; 0D -> OR; 0E -> XOR; 0A -> SLT; 0F -> LUI.
  - 23 = lw and 2B = sw, both ADD.
  - 04 -> BEQ; 05 -> BNE; 06 -> BLEZ; 07 -> BGTZ; 01 with rt = 1 -> BGEZ.
  - 02 = j; 03 = jal.
- EXEC:
  - ALU ops -> WB.
  - lw/sw -> MEM.
  - Branch: sample zero in EXEC. zero = 0 means the condition holds: pc_src = 1. Otherwise pc_src = 0. Pulse pc_write, then FETCH.
  - j: pc_src = 2. jal: pc_src = 2 plus link and reg_write. jr: pc_src = 3. All pulse pc_write in EXEC, then FETCH.
- MEM:
  - Hold mem_req high until the cycle mem_ack = 1.
  - mem_ack in the same cycle mem_req first rises counts as completion.
  - lw -> WB with mem_to_reg = 1.
  - sw -> pulse pc_write (pc_src 0), then FETCH.
- WB: reg_write and pc_write (pc_src 0) pulse for exactly one cycle, then FETCH.
- Instruction latency: ALU op 4 cycles from accept to the next inst_ready; lw 5 + (mem_ack wait) cycles.
- syscall:
  - In EXEC, set halted and enter HALT.
  - HALT: inst_ready = 0 and no strobes until rst_b = 0.
- Illegal opcode or funct:
  - Pulse illegal in EXEC and treat as NOP: pc_write with pc_src 0, no reg_write or mem_req.
- rst_b low in any state, including MEM with mem_req high: all outputs take reset values at that edge; the in-flight instruction is discarded.
- pc_write is asserted exactly once per non-halting instruction.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined and MEM_WAIT_MAX > 0:
  - A MEM cycle counter runs while waiting.
  - If it reaches MEM_WAIT_MAX without mem_ack: drop mem_req, set mem_timeout, enter HALT.
- Undefined: counter absent, mem_timeout tied 0, MEM waits indefinitely.

Decomposition:
- Package mips_ctrl_pkg holds:
  - ALU op localparams, with values identical to the list above.
  - Opcode and funct constants.
  - State enum: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - pc_src encodings.
- Sub-module mips_main_decoder: combinational IR -> control bundle, including illegal.
- Top level holds the FSM and output registers.

Test Plan:
- add $3,$1,$2 (0x00221820): accept -> alu_op 00100, reg_dst_rd 1; reg_write in WB; one pc_write; inst_ready again 4 cycles after accept.
- beq (0x10220003) with zero 0 -> alu_op 01101, pc_src 1, pc_write in EXEC. Same instruction with zero 1 -> pc_src 0, no reg_write.
- lw (0x8C230004), mem_ack after 3 cycles -> mem_req high 3 cycles, mem_we 0; then WB with mem_to_reg 1 and reg_write.
- syscall (0x0000000C) -> halted 1, inst_ready stays 0 for 20 cycles; one-cycle rst_b pulse -> FETCH, halted 0.
- rst_b low while in MEM with mem_req 1 -> next edge: mem_req 0, alu_op 00000, state FETCH.
- opcode 0x3F (0xFC000000) -> illegal pulse, no reg_write, pc_write with pc_src 0. With MEM_TIMEOUT_EN and MEM_WAIT_MAX = 4, sw with no mem_ack -> mem_timeout after 4 cycles, then HALT.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: ALU ops, opcodes, functs,
// FSM states, PC source selects and the decoded control bundle.
package mips_ctrl_pkg;

    localparam logic [4:0] ALU_XOR  = 5'b00000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLLV = 5'b11001;
    localparam logic [4:0] ALU_SRL  = 5'b00010;
    localparam logic [4:0] ALU_SRLV = 5'b11010;
    localparam logic [4:0] ALU_SRA  = 5'b00011;
    localparam logic [4:0] ALU_ADD  = 5'b00100;
    localparam logic [4:0] ALU_SUB  = 5'b00101;
    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
    localparam logic [4:0] ALU_OR   = 5'b01000;
    localparam logic [4:0] ALU_NOR  = 5'b01001;
    localparam logic [4:0] ALU_AND  = 5'b01010;
    localparam logic [4:0] ALU_SLT  = 5'b01011;
    localparam logic [4:0] ALU_BEQ  = 5'b01101;
    localparam logic [4:0] ALU_BNE  = 5'b01110;
    localparam logic [4:0] ALU_BLEZ = 5'b01111;
    localparam logic [4:0] ALU_BGTZ = 5'b10000;
    localparam logic [4:0] ALU_BGEZ = 5'b10001;
    localparam logic [4:0] ALU_LUI  = 5'b10010;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

    typedef enum logic [3:0] {
        KIND_ALU, KIND_LOAD, KIND_STORE, KIND_BRANCH, KIND_JUMP,
        KIND_JAL, KIND_JR, KIND_SYSCALL, KIND_ILLEGAL
    } kind_e;

    typedef struct packed {
        kind_e      kind;
        logic [4:0] alu_op;
        logic       alu_src_imm;
        logic       imm_zero_ext;
        logic       reg_dst_rd;
        logic       mem_to_reg;
        logic       mem_we;
        logic       link;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{kind: KIND_ALU, alu_op: ALU_XOR, alu_src_imm: 1'b0,
                                     imm_zero_ext: 1'b0, reg_dst_rd: 1'b0, mem_to_reg: 1'b0,
                                     mem_we: 1'b0, link: 1'b0};

    localparam ctrl_t CTRL_ILLEGAL = '{kind: KIND_ILLEGAL, alu_op: ALU_XOR, alu_src_imm: 1'b0,
                                       imm_zero_ext: 1'b0, reg_dst_rd: 1'b0, mem_to_reg: 1'b0,
                                       mem_we: 1'b0, link: 1'b0};

endpackage

// File: rtl/mips_main_decoder.sv
// Combinational instruction decoder: instruction word -> control bundle.
// Anything not in the supported opcode/funct set decodes as KIND_ILLEGAL.
module mips_main_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_t       ctrl
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       unused_fields;

    assign opcode = inst[31:26];
    assign funct  = inst[5:0];
    assign rt     = inst[20:16];
    assign unused_fields = ^{inst[25:21], inst[15:6]};

    always_comb begin
        ctrl = CTRL_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                ctrl.kind       = KIND_ALU;
                ctrl.reg_dst_rd = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
                    FN_AND:          ctrl.alu_op = ALU_AND;
                    FN_OR:           ctrl.alu_op = ALU_OR;
                    FN_XOR:          ctrl.alu_op = ALU_XOR;
                    FN_NOR:          ctrl.alu_op = ALU_NOR;
                    FN_SLT:          ctrl.alu_op = ALU_SLT;
                    FN_SLL:          ctrl.alu_op = ALU_SLL;
                    FN_SRL:          ctrl.alu_op = ALU_SRL;
                    FN_SRA:          ctrl.alu_op = ALU_SRA;
                    FN_SLLV:         ctrl.alu_op = ALU_SLLV;
                    FN_SRLV:         ctrl.alu_op = ALU_SRLV;
                    FN_MULT:         ctrl.alu_op = ALU_MULT;
                    FN_DIV:          ctrl.alu_op = ALU_DIV;
                    FN_JR: begin
                        ctrl.kind       = KIND_JR;
                        ctrl.reg_dst_rd = 1'b0;
                    end
                    FN_SYSCALL: begin
                        ctrl.kind       = KIND_SYSCALL;
                        ctrl.reg_dst_rd = 1'b0;
                    end
                    default: ctrl = CTRL_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl.kind = KIND_ALU; ctrl.alu_op = ALU_ADD; ctrl.alu_src_imm = 1'b1;
            end
            OP_SLTI: begin
                ctrl.kind = KIND_ALU; ctrl.alu_op = ALU_SLT; ctrl.alu_src_imm = 1'b1;
            end
            OP_ANDI: begin
                ctrl.kind = KIND_ALU; ctrl.alu_op = ALU_AND; ctrl.alu_src_imm = 1'b1;
                ctrl.imm_zero_ext = 1'b1;
            end
            OP_ORI: begin
                ctrl.kind = KIND_ALU; ctrl.alu_op = ALU_OR; ctrl.alu_src_imm = 1'b1;
                ctrl.imm_zero_ext = 1'b1;
            end
            OP_XORI: begin
                ctrl.kind = KIND_ALU; ctrl.alu_op = ALU_XOR; ctrl.alu_src_imm = 1'b1;
                ctrl.imm_zero_ext = 1'b1;
            end
            OP_LUI: begin
                ctrl.kind = KIND_ALU; ctrl.alu_op = ALU_LUI; ctrl.alu_src_imm = 1'b1;
            end
            OP_LW: begin
                ctrl.kind = KIND_LOAD; ctrl.alu_op = ALU_ADD; ctrl.alu_src_imm = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl.kind = KIND_STORE; ctrl.alu_op = ALU_ADD; ctrl.alu_src_imm = 1'b1;
                ctrl.mem_we = 1'b1;
            end
            OP_BEQ:  begin ctrl.kind = KIND_BRANCH; ctrl.alu_op = ALU_BEQ;  end
            OP_BNE:  begin ctrl.kind = KIND_BRANCH; ctrl.alu_op = ALU_BNE;  end
            OP_BLEZ: begin ctrl.kind = KIND_BRANCH; ctrl.alu_op = ALU_BLEZ; end
            OP_BGTZ: begin ctrl.kind = KIND_BRANCH; ctrl.alu_op = ALU_BGTZ; end
            OP_REGIMM: begin
                // Only bgez (rt = 1) is supported in the REGIMM group
                if (rt == 5'd1) begin
                    ctrl.kind = KIND_BRANCH; ctrl.alu_op = ALU_BGEZ;
                end
            end
            OP_J:   ctrl.kind = KIND_JUMP;
            OP_JAL: begin ctrl.kind = KIND_JAL; ctrl.link = 1'b1; end
            default: ctrl = CTRL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: fetch handshake, decode register, exec/mem/wb sequencing.
// Optional MEM_TIMEOUT_EN bounds the MEM wait to MEM_WAIT_MAX cycles (0 = unbounded).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 0
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    output logic        inst_ready,
    output logic [4:0]  alu_op,
    input  logic        zero,
    output logic        alu_src_imm,
    output logic        imm_zero_ext,
    output logic        reg_dst_rd,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        link,
    output logic        illegal,
    output logic        halted,
    output logic        mem_timeout
);

    state_e      state_q, state_d;
    logic [31:0] ir_q;
    ctrl_t       dec, ctrl_q;
    logic        halted_q, set_halt;
    logic        wait_expired;

    mips_main_decoder u_dec (
        .inst (ir_q),
        .ctrl (dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q  <= FETCH;
            ir_q     <= '0;
            ctrl_q   <= CTRL_RESET;
            halted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && inst_valid) ir_q <= inst;
            if (state_q == DECODE) ctrl_q <= dec;
            if (set_halt) halted_q <= 1'b1;
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [31:0] wait_q;
    logic        timeout_q;

    assign wait_expired = (MEM_WAIT_MAX > 0) && (state_q == MEM) && !mem_ack &&
                          (wait_q == MEM_WAIT_MAX - 32'd1);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q <= (state_q == MEM && !mem_ack) ? wait_q + 32'd1 : 32'd0;
            if (wait_expired) timeout_q <= 1'b1;
        end
    end

    assign mem_timeout = timeout_q;
`else
    logic unused_wait_max;
    assign unused_wait_max = ^MEM_WAIT_MAX;
    assign wait_expired    = 1'b0;
    assign mem_timeout     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        inst_ready = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SEQ;
        reg_write  = 1'b0;
        mem_req    = 1'b0;
        illegal    = 1'b0;
        set_halt   = 1'b0;
        unique case (state_q)
            FETCH: begin
                inst_ready = 1'b1;
                if (inst_valid) state_d = DECODE;
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                state_d = FETCH;
                unique case (ctrl_q.kind)
                    KIND_ALU:               state_d = WB;
                    KIND_LOAD, KIND_STORE:  state_d = MEM;
                    KIND_BRANCH: begin
                        // zero low means the branch condition holds
                        pc_write = 1'b1;
                        pc_src   = zero ? PC_SEQ : PC_BRANCH;
                    end
                    KIND_JUMP: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                    end
                    KIND_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = PC_JUMP;
                        reg_write = 1'b1;
                    end
                    KIND_JR: begin
                        pc_write = 1'b1;
                        pc_src   = PC_REG;
                    end
                    KIND_SYSCALL: begin
                        set_halt = 1'b1;
                        state_d  = HALT;
                    end
                    KIND_ILLEGAL: begin
                        illegal  = 1'b1;
                        pc_write = 1'b1;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (ctrl_q.kind == KIND_STORE) begin
                        pc_write = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_expired) begin
                    state_d = HALT;
                end
            end
            WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    assign alu_op       = ctrl_q.alu_op;
    assign alu_src_imm  = ctrl_q.alu_src_imm;
    assign imm_zero_ext = ctrl_q.imm_zero_ext;
    assign reg_dst_rd   = ctrl_q.reg_dst_rd;
    assign mem_to_reg   = ctrl_q.mem_to_reg;
    assign mem_we       = ctrl_q.mem_we;
    assign link         = ctrl_q.link;
    assign halted       = halted_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl; inputs driven and outputs sampled on negedge.
module tb_mips_multicycle_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WAIT_MAX = 4;
`else
    localparam int unsigned WAIT_MAX = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [4:0]  alu_op;
    logic        zero;
    logic        alu_src_imm;
    logic        imm_zero_ext;
    logic        reg_dst_rd;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        link;
    logic        illegal;
    logic        halted;
    logic        mem_timeout;

    int checks   = 0;
    int failures = 0;
    int pcw_cnt  = 0;
    int pcw_base;

    mips_multicycle_ctrl #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .alu_op       (alu_op),
        .zero         (zero),
        .alu_src_imm  (alu_src_imm),
        .imm_zero_ext (imm_zero_ext),
        .reg_dst_rd   (reg_dst_rd),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_ack      (mem_ack),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .link         (link),
        .illegal      (illegal),
        .halted       (halted),
        .mem_timeout  (mem_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (pc_write === 1'b1) pcw_cnt <= pcw_cnt + 1;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one instruction for a single FETCH cycle; returns in DECODE
    task automatic accept(input logic [31:0] word);
        inst       = word;
        inst_valid = 1'b1;
        check("accept_ready", {31'd0, inst_ready}, 32'd1);
        tick();
        inst_valid = 1'b0;
    endtask

    initial begin
        rst_b = 1'b0; inst = '0; inst_valid = 1'b0; zero = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        tick();
        check("rst_alu_op", {27'd0, alu_op}, 32'd0);
        check("rst_pc_write", {31'd0, pc_write}, 32'd0);
        check("rst_reg_write", {31'd0, reg_write}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_mem_timeout", {31'd0, mem_timeout}, 32'd0);
        check("rst_inst_ready", {31'd0, inst_ready}, 32'd1);
        rst_b = 1'b1;
        tick();

        // add $3,$1,$2
        pcw_base = pcw_cnt;
        accept(32'h00221820);
        check("add_dec_ready", {31'd0, inst_ready}, 32'd0);
        tick();
        check("add_alu_op", {27'd0, alu_op}, 32'h04);
        check("add_reg_dst", {31'd0, reg_dst_rd}, 32'd1);
        check("add_exec_pcw", {31'd0, pc_write}, 32'd0);
        tick();
        check("add_wb_regw", {31'd0, reg_write}, 32'd1);
        check("add_wb_pcw", {31'd0, pc_write}, 32'd1);
        check("add_wb_pcsrc", {30'd0, pc_src}, 32'd0);
        check("add_wb_ready", {31'd0, inst_ready}, 32'd0);
        tick();
        check("add_ready4", {31'd0, inst_ready}, 32'd1);
        check("add_alu_hold", {27'd0, alu_op}, 32'h04);
        check("add_pcw_once", pcw_cnt - pcw_base, 32'd1);

        // beq taken (zero = 0)
        accept(32'h10220003);
        tick();
        check("beq_t_alu_op", {27'd0, alu_op}, 32'h0D);
        check("beq_t_pcsrc", {30'd0, pc_src}, 32'd1);
        check("beq_t_pcw", {31'd0, pc_write}, 32'd1);
        check("beq_t_regw", {31'd0, reg_write}, 32'd0);
        tick();
        check("beq_t_ready", {31'd0, inst_ready}, 32'd1);

        // beq not taken (zero = 1)
        accept(32'h10220003);
        zero = 1'b1;
        tick();
        check("beq_n_pcsrc", {30'd0, pc_src}, 32'd0);
        check("beq_n_pcw", {31'd0, pc_write}, 32'd1);
        check("beq_n_regw", {31'd0, reg_write}, 32'd0);
        tick();
        zero = 1'b0;
        check("beq_n_ready", {31'd0, inst_ready}, 32'd1);

        // lw with mem_ack in the third MEM cycle
        accept(32'h8C230004);
        tick();
        check("lw_alu_op", {27'd0, alu_op}, 32'h04);
        check("lw_src_imm", {31'd0, alu_src_imm}, 32'd1);
        check("lw_exec_req", {31'd0, mem_req}, 32'd0);
        tick();
        check("lw_req1", {31'd0, mem_req}, 32'd1);
        check("lw_we", {31'd0, mem_we}, 32'd0);
        tick();
        check("lw_req2", {31'd0, mem_req}, 32'd1);
        tick();
        mem_ack = 1'b1;
        check("lw_req3", {31'd0, mem_req}, 32'd1);
        check("lw_mem_pcw", {31'd0, pc_write}, 32'd0);
        tick();
        mem_ack = 1'b0;
        check("lw_wb_req", {31'd0, mem_req}, 32'd0);
        check("lw_wb_m2r", {31'd0, mem_to_reg}, 32'd1);
        check("lw_wb_regw", {31'd0, reg_write}, 32'd1);
        check("lw_wb_pcw", {31'd0, pc_write}, 32'd1);
        check("lw_wb_rt", {31'd0, reg_dst_rd}, 32'd0);
        tick();
        check("lw_ready", {31'd0, inst_ready}, 32'd1);

        // jal
        accept(32'h0C000010);
        tick();
        check("jal_pcsrc", {30'd0, pc_src}, 32'd2);
        check("jal_link", {31'd0, link}, 32'd1);
        check("jal_regw", {31'd0, reg_write}, 32'd1);
        check("jal_pcw", {31'd0, pc_write}, 32'd1);
        tick();

        // jr $31
        accept(32'h03E00008);
        tick();
        check("jr_pcsrc", {30'd0, pc_src}, 32'd3);
        check("jr_pcw", {31'd0, pc_write}, 32'd1);
        check("jr_regw", {31'd0, reg_write}, 32'd0);
        tick();

        // ori $2,$1,5
        accept(32'h34220005);
        tick();
        check("ori_alu_op", {27'd0, alu_op}, 32'h08);
        check("ori_zext", {31'd0, imm_zero_ext}, 32'd1);
        check("ori_src_imm", {31'd0, alu_src_imm}, 32'd1);
        tick();
        tick();

        // srlv $3,$2,$1
        accept(32'h00221806);
        tick();
        check("srlv_alu_op", {27'd0, alu_op}, 32'h1A);
        tick();
        tick();

        // bgez $1
        accept(32'h04210002);
        tick();
        check("bgez_alu_op", {27'd0, alu_op}, 32'h11);
        check("bgez_pcw", {31'd0, pc_write}, 32'd1);
        tick();

        // sw with mem_ack on the first MEM cycle
        accept(32'hAC230004);
        tick();
        mem_ack = 1'b1;
        tick();
        check("sw_req", {31'd0, mem_req}, 32'd1);
        check("sw_we", {31'd0, mem_we}, 32'd1);
        check("sw_pcw", {31'd0, pc_write}, 32'd1);
        check("sw_pcsrc", {30'd0, pc_src}, 32'd0);
        check("sw_regw", {31'd0, reg_write}, 32'd0);
        tick();
        mem_ack = 1'b0;
        check("sw_ready", {31'd0, inst_ready}, 32'd1);

        // illegal opcode 0x3F
        accept(32'hFC000000);
        tick();
        check("ill_pulse", {31'd0, illegal}, 32'd1);
        check("ill_pcw", {31'd0, pc_write}, 32'd1);
        check("ill_pcsrc", {30'd0, pc_src}, 32'd0);
        check("ill_regw", {31'd0, reg_write}, 32'd0);
        check("ill_req", {31'd0, mem_req}, 32'd0);
        tick();
        check("ill_clear", {31'd0, illegal}, 32'd0);

        // reset while in MEM with mem_req high
        accept(32'h8C230004);
        tick();
        tick();
        check("rstmem_req_before", {31'd0, mem_req}, 32'd1);
        rst_b = 1'b0;
        tick();
        check("rstmem_req", {31'd0, mem_req}, 32'd0);
        check("rstmem_alu_op", {27'd0, alu_op}, 32'd0);
        check("rstmem_fetch", {31'd0, inst_ready}, 32'd1);
        check("rstmem_m2r", {31'd0, mem_to_reg}, 32'd0);
        rst_b = 1'b1;
        tick();
        check("pcw_total", pcw_cnt, 32'd11);

        // syscall halts until reset
        pcw_base = pcw_cnt;
        accept(32'h0000000C);
        tick();
        check("sys_exec_pcw", {31'd0, pc_write}, 32'd0);
        inst_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("sys_halted", {31'd0, halted}, 32'd1);
            check("sys_ready", {31'd0, inst_ready}, 32'd0);
        end
        inst_valid = 1'b0;
        check("sys_no_pcw", pcw_cnt - pcw_base, 32'd0);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        check("sys_rst_halted", {31'd0, halted}, 32'd0);
        tick();
        check("sys_rst_ready", {31'd0, inst_ready}, 32'd1);

`ifdef MEM_TIMEOUT_EN
        // sw with no mem_ack times out after WAIT_MAX MEM cycles
        accept(32'hAC230004);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_req", {31'd0, mem_req}, 32'd1);
            check("to_flag_low", {31'd0, mem_timeout}, 32'd0);
        end
        tick();
        check("to_req_drop", {31'd0, mem_req}, 32'd0);
        check("to_flag", {31'd0, mem_timeout}, 32'd1);
        check("to_halt_ready", {31'd0, inst_ready}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
